npxl_vu_controller: RTL and testbench

// Self-contained WS2812 ("NeoPixel") VU-meter strip controller, successor to the fixed 20-LED ROM-based controller.

---
 rtl/npxl_vu_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_npxl_vu_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/npxl_vu_controller.sv
// NeoPixel (WS2812) VU-meter strip controller.
// Turns a level sample into a bar graph with a peak-hold marker, applies a
// colour mode and global brightness, and serialises the frame on one wire.
//
// Handshake: o_rdy=1 means the controller is idle. A frame starts on any cycle
// where o_rdy=1 and i_send=1; level, mode and brightness are captured on that
// cycle. i_send is ignored whenever o_rdy=0.
module npxl_vu_controller #(
    parameter int CLK_HZ           = 48_000_000,
    parameter int LEDS             = 20,
    parameter int LVL_W            = 8,
    parameter int T0H_NS           = 350,
    parameter int T1H_NS           = 700,
    parameter int TBIT_NS          = 1250,
    parameter int TRES_US          = 80,
    parameter int PEAK_HOLD_FRAMES = 30
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [LVL_W-1:0] i_level,
    input  logic [1:0]       i_mode,
    input  logic [7:0]       i_bright,
    input  logic             i_send,
    output logic             o_npxl_data,
    output logic             o_rdy,
    output logic [2:0]       dbg_state
);

    // Bit timings in clock cycles, rounded up
    localparam longint NS_PER_S = 64'd1_000_000_000;
    localparam int T0H  = int'((longint'(CLK_HZ) * T0H_NS  + NS_PER_S - 1) / NS_PER_S);
    localparam int T1H  = int'((longint'(CLK_HZ) * T1H_NS  + NS_PER_S - 1) / NS_PER_S);
    localparam int TBIT = int'((longint'(CLK_HZ) * TBIT_NS + NS_PER_S - 1) / NS_PER_S);
    localparam int TRES = (CLK_HZ / 1_000_000) * TRES_US;

    localparam int CNT_MAX = (TRES > TBIT) ? TRES : TBIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(LEDS + 1);
    localparam int HOLD_W  = (PEAK_HOLD_FRAMES > 0) ? $clog2(PEAK_HOLD_FRAMES + 1) : 1;
    localparam int STEP    = 255 / (LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_BIT_HI = 3'd2,
        S_BIT_LO = 3'd3,
        S_LATCH  = 3'd4
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    led_idx;
    logic [4:0]          bit_idx;
    logic [23:0]         shreg;
    logic [IDX_W-1:0]    lit_q;
    logic [IDX_W-1:0]    peak;
    logic [HOLD_W-1:0]   hold;
    logic [1:0]          mode_q;
    logic [7:0]          bright_q;
    logic                data;
    logic                rdy;

    logic [IDX_W-1:0]    lit_new;
    logic [CNT_W-1:0]    hi_len;
    logic [23:0]         next_colour;

    // Brightness scaling of one channel: (c * (bright + 1)) >> 8
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] br);
        logic [15:0] p;
        p = 16'(c) * (16'(br) + 16'd1);
        return 8'(p >> 8);
    endfunction

    // Scaled GRB colour of LED k for the captured frame parameters
    function automatic logic [23:0] led_colour(input logic [IDX_W-1:0] k,
                                               input logic [IDX_W-1:0] n,
                                               input logic [IDX_W-1:0] pk,
                                               input logic [1:0]       md,
                                               input logic [7:0]       br);
        logic [7:0]  g;
        logic [7:0]  r;
        logic [7:0]  b;
        logic [31:0] kk;
        g  = 8'h00;
        r  = 8'h00;
        b  = 8'h00;
        kk = 32'(k);
        if (md == 2'd3) begin
            g = 8'hFF;
            r = 8'hFF;
            b = 8'hFF;
        end else if (k < n) begin
            case (md)
                2'd0: begin
                    if (kk * 32'd20 < 32'(LEDS * 12)) begin
                        g = 8'hFF;
                    end else if (kk * 32'd20 < 32'(LEDS * 17)) begin
                        g = 8'hFF;
                        r = 8'hFF;
                    end else begin
                        r = 8'hFF;
                    end
                end
                2'd1: b = 8'hFF;
                default: begin
                    r = 8'(32'd255 - kk * 32'(STEP));
                    b = 8'(kk * 32'(STEP));
                end
            endcase
        end else if ((pk > n) && (k == pk - IDX_W'(1))) begin
            g = 8'hFF;
            r = 8'hFF;
            b = 8'hFF;
        end
        return {scale(g, br), scale(r, br), scale(b, br)};
    endfunction

    // Lit count from the raw level, high-time of the current bit, next LED colour
    always_comb begin
        lit_new     = IDX_W'((32'(i_level) * 32'(LEDS + 1)) >> LVL_W);
        hi_len      = shreg[23] ? CNT_W'(T1H) : CNT_W'(T0H);
        next_colour = led_colour(led_idx + IDX_W'(1), lit_q, peak, mode_q, bright_q);
    end

    // Frame sequencer: capture, peak update, bit timing, latch gap
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_LATCH;
            cnt      <= '0;
            led_idx  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            lit_q    <= '0;
            peak     <= '0;
            hold     <= '0;
            mode_q   <= '0;
            bright_q <= '0;
            data     <= 1'b0;
            rdy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_send) begin
                        lit_q    <= lit_new;
                        mode_q   <= i_mode;
                        bright_q <= i_bright;
                        rdy      <= 1'b0;
                        state    <= S_LOAD;
                        if (lit_new >= peak) begin
                            peak <= lit_new;
                            hold <= HOLD_W'(PEAK_HOLD_FRAMES);
                        end else if (hold != '0) begin
                            hold <= hold - HOLD_W'(1);
                        end else begin
                            peak <= peak - IDX_W'(1);
                        end
                    end
                end
                S_LOAD: begin
                    shreg   <= led_colour('0, lit_q, peak, mode_q, bright_q);
                    led_idx <= '0;
                    bit_idx <= '0;
                    cnt     <= '0;
                    data    <= 1'b1;
                    state   <= S_BIT_HI;
                end
                S_BIT_HI: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == hi_len - CNT_W'(1)) begin
                        data  <= 1'b0;
                        state <= S_BIT_LO;
                    end
                end
                S_BIT_LO: begin
                    if (cnt == CNT_W'(TBIT - 1)) begin
                        cnt <= '0;
                        if (bit_idx == 5'd23) begin
                            if (led_idx == IDX_W'(LEDS - 1)) begin
                                state <= S_LATCH;
                            end else begin
                                led_idx <= led_idx + IDX_W'(1);
                                bit_idx <= '0;
                                shreg   <= next_colour;
                                data    <= 1'b1;
                                state   <= S_BIT_HI;
                            end
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                            shreg   <= {shreg[22:0], 1'b0};
                            data    <= 1'b1;
                            state   <= S_BIT_HI;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_LATCH: begin
                    if (cnt == CNT_W'(TRES - 1)) begin
                        cnt   <= '0;
                        rdy   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    data  <= 1'b0;
                    rdy   <= 1'b0;
                    state <= S_LATCH;
                end
            endcase
        end
    end

    assign o_npxl_data = data;
    assign o_rdy       = rdy;
    assign dbg_state   = state;

endmodule

// File: tb/tb_npxl_vu_controller.sv
// Bench for npxl_vu_controller: decodes the serial line back into LED words
// and compares them with a reference model of the bar/peak/colour rules.
module tb_npxl_vu_controller;

    // Scaled-down configuration so many frames fit in a short run
    localparam int CLK_HZ = 8_000_000;
    localparam int LEDS   = 8;
    localparam int HOLD   = 3;
    localparam int TRESU  = 4;
    // Expected cycle timings at 8 MHz: ceil(2.8)=3, ceil(5.6)=6, 10, 8*4=32
    localparam int T0H    = 3;
    localparam int T1H    = 6;
    localparam int TBIT   = 10;
    localparam int TRES   = 32;
    localparam int NBITS  = LEDS * 24;
    localparam int FRAME_BUDGET = NBITS * TBIT + TRES + 200;

    logic       clk;
    logic       i_rst;
    logic [7:0] i_level;
    logic [1:0] i_mode;
    logic [7:0] i_bright;
    logic       i_send;
    logic       o_npxl_data;
    logic       o_rdy;
    logic [2:0] dbg_state;

    int n_checks;
    int n_errors;

    // Reference peak state
    int m_peak;
    int m_hold;

    logic [23:0] exp_q[$];

    npxl_vu_controller #(
        .CLK_HZ(CLK_HZ), .LEDS(LEDS), .LVL_W(8), .T0H_NS(350), .T1H_NS(700),
        .TBIT_NS(1250), .TRES_US(TRESU), .PEAK_HOLD_FRAMES(HOLD)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_level(i_level), .i_mode(i_mode),
        .i_bright(i_bright), .i_send(i_send), .o_npxl_data(o_npxl_data),
        .o_rdy(o_rdy), .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_lit(input int lvl);
        return (lvl * (LEDS + 1)) / 256;
    endfunction

    function automatic int ref_scale(input int c, input int br);
        return (c * (br + 1)) / 256;
    endfunction

    function automatic logic [23:0] ref_led(input int k, input int n, input int pk,
                                            input int md, input int br);
        int g, r, b;
        int pct;
        g = 0; r = 0; b = 0;
        if (md == 3) begin
            g = 255; r = 255; b = 255;
        end else if (k < n) begin
            if (md == 0) begin
                // position along the strip in units of LEDS/20
                pct = k * 20;
                if (pct < LEDS * 12)      g = 255;
                else if (pct < LEDS * 17) begin g = 255; r = 255; end
                else                      r = 255;
            end else if (md == 1) begin
                b = 255;
            end else begin
                r = 255 - k * (255 / (LEDS - 1));
                b = k * (255 / (LEDS - 1));
            end
        end else if (pk > n && k == pk - 1) begin
            g = 255; r = 255; b = 255;
        end
        return {8'(ref_scale(g, br)), 8'(ref_scale(r, br)), 8'(ref_scale(b, br))};
    endfunction

    // Frame start: update the model peak and queue the expected LED words
    task automatic model_frame(input int lvl, input int md, input int br);
        int n;
        n = ref_lit(lvl);
        if (n >= m_peak) begin
            m_peak = n;
            m_hold = HOLD;
        end else if (m_hold != 0) begin
            m_hold = m_hold - 1;
        end else begin
            m_peak = m_peak - 1;
        end
        exp_q.delete();
        for (int k = 0; k < LEDS; k++) exp_q.push_back(ref_led(k, n, m_peak, md, br));
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string tag);
        int c;
        c = 0;
        while (!o_rdy && c < FRAME_BUDGET) begin
            @(negedge clk);
            c++;
        end
        if (!o_rdy) check({tag, "_ready_timeout"}, 32'(o_rdy), 32'd1);
    endtask

    // Called at the first negedge after a reset edge; counts low-rdy cycles
    task automatic check_latch(input string tag);
        int low;
        int hi;
        low = 0;
        hi = 0;
        while (!o_rdy && low < TRES + 100) begin
            if (o_npxl_data) hi++;
            low++;
            @(negedge clk);
        end
        check({tag, "_rdy_gap"}, 32'(low), 32'(TRES));
        check({tag, "_line_low"}, 32'(hi), 32'd0);
    endtask

    task automatic start_frame(input int lvl, input int md, input int br);
        i_level  = 8'(lvl);
        i_mode   = 2'(md);
        i_bright = 8'(br);
        i_send   = 1'b1;
        @(negedge clk);
        i_send   = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int lvl, input int md, input int br,
                             input bit mid_send);
        logic bits[$];
        int hi, first_rise, last_rise, bad_hi, bad_per, fall_cyc, end_cyc, last_th;
        bit prev, pulsed, done;
        logic [23:0] word;
        logic [23:0] exp_word;
        wait_ready(tag);
        model_frame(lvl, md, br);
        start_frame(lvl, md, br);
        check({tag, "_rdy_clear"}, 32'(o_rdy), 32'd0);
        hi = 0; first_rise = -1; last_rise = -1; bad_hi = 0; bad_per = 0;
        fall_cyc = -1; end_cyc = -1; prev = 1'b0; pulsed = 1'b0; done = 1'b0;
        for (int c = 0; c < FRAME_BUDGET; c++) begin
            if (mid_send && !pulsed && bits.size() == 50) begin
                i_send = 1'b1;
                pulsed = 1'b1;
            end else begin
                i_send = 1'b0;
            end
            if (o_npxl_data) begin
                if (!prev) begin
                    if (first_rise < 0) first_rise = c;
                    else if (c - last_rise != TBIT) bad_per++;
                    last_rise = c;
                    hi = 0;
                end
                hi++;
            end else if (prev) begin
                if (hi == T1H)      bits.push_back(1'b1);
                else if (hi == T0H) bits.push_back(1'b0);
                else begin
                    bad_hi++;
                    bits.push_back(1'b0);
                end
                fall_cyc = c;
            end
            prev = o_npxl_data;
            if (o_rdy) begin
                done = 1'b1;
                end_cyc = c;
                break;
            end
            @(negedge clk);
        end
        i_send = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_first_rise"}, 32'(first_rise), 32'd1);
        check({tag, "_bit_count"}, 32'(bits.size()), 32'(NBITS));
        check({tag, "_bad_high_time"}, 32'(bad_hi), 32'd0);
        check({tag, "_bad_period"}, 32'(bad_per), 32'd0);
        last_th = exp_q[LEDS-1][0] ? T1H : T0H;
        check({tag, "_latch_gap"}, 32'(end_cyc - fall_cyc), 32'(TBIT - last_th + TRES));
        for (int k = 0; k < LEDS; k++) begin
            word = '0;
            for (int j = 0; j < 24; j++) begin
                if (k * 24 + j < bits.size()) word = {word[22:0], bits[k * 24 + j]};
                else                          word = {word[22:0], 1'b0};
            end
            exp_word = exp_q.pop_front();
            check($sformatf("%s_led%0d", tag, k), 32'(word), 32'(exp_word));
        end
    endtask

    // Start a frame, then pulse reset after at_bit completed bits
    task automatic abort_frame(input string tag, input int lvl, input int md, input int br,
                               input int at_bit);
        int falls;
        bit prev;
        wait_ready(tag);
        model_frame(lvl, md, br);
        start_frame(lvl, md, br);
        falls = 0;
        prev = 1'b0;
        for (int c = 0; c < FRAME_BUDGET && falls < at_bit; c++) begin
            if (!o_npxl_data && prev) falls++;
            prev = o_npxl_data;
            if (falls < at_bit) @(negedge clk);
        end
        check({tag, "_reached_bit"}, 32'(falls), 32'(at_bit));
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check({tag, "_line_low_next"}, 32'(o_npxl_data), 32'd0);
        m_peak = 0;
        m_hold = 0;
        exp_q.delete();
        check_latch(tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        m_peak   = 0;
        m_hold   = 0;
        i_rst    = 1'b1;
        i_level  = '0;
        i_mode   = '0;
        i_bright = '0;
        i_send   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        check_latch("reset");

        run_frame("blue_full", 255, 1, 255, 1'b0);
        run_frame("vu_half", 128, 0, 255, 1'b0);
        run_frame("vu_full", 255, 0, 255, 1'b0);
        run_frame("grad", 200, 2, 255, 1'b0);
        run_frame("blue_dim", 255, 1, 63, 1'b0);
        run_frame("test_pat", 0, 3, 255, 1'b0);
        run_frame("mid_send", 255, 1, 255, 1'b1);

        // Peak decay: full frame then silent frames
        run_frame("decay0", 255, 1, 255, 1'b0);
        for (int f = 1; f <= HOLD + 3; f++) begin
            run_frame($sformatf("decay%0d", f), 0, 1, 255, 1'b0);
        end

        abort_frame("abort", 255, 0, 255, 100);
        run_frame("after_abort", 60, 0, 200, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_frame($sformatf("rand%0d", r), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
